// File: rtl/top_mul_pkg.sv
// Shared types and helpers for the pipelined multiply / MAC lane.
// sat_add is only referenced when TOP_MUL_SAT_EN is defined.
package top_mul_pkg;

  typedef struct packed {
    logic valid;
    logic acc_en;
    logic acc_first;
  } stage_ctl_t;

  localparam int SAT_W = 64;

  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  // Operands arrive already extended to SAT_W; the result is clamped to the w-bit range.
  // Bit SAT_W of the return value flags that a clamp happened.
  function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] a,
                                             input logic [SAT_W-1:0] b,
                                             input int w, input logic sgn);
    logic signed [SAT_W+1:0] s, hi, lo;
    localparam logic signed [SAT_W+1:0] ONE = 1;
    if (sgn) s = $signed({{2{a[SAT_W-1]}}, a}) + $signed({{2{b[SAT_W-1]}}, b});
    else     s = $signed({2'b00, a}) + $signed({2'b00, b});
    hi = sgn ? (ONE <<< (w - 1)) - ONE : (ONE <<< w) - ONE;
    lo = sgn ? -(ONE <<< (w - 1)) : '0;
    if (s > hi) return {1'b1, hi[SAT_W-1:0]};
    if (s < lo) return {1'b1, lo[SAT_W-1:0]};
    return {1'b0, s[SAT_W-1:0]};
  endfunction

endpackage

// File: rtl/top_mul_pipe_delay.sv
// ce-gated shift register, DEPTH stages of W bits; DEPTH 0 is a plain wire.
module top_mul_pipe_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = ^{clk, reset, ce};
      assign q = d;
    end else begin : g_sr
      logic [DEPTH-1:0][W-1:0] sr;
      always_ff @(posedge clk) begin
        if (reset) begin
          sr <= '0;
        end else if (ce) begin
          sr[0] <= d;
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end
      assign q = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/top_mul_pipe_mac.sv
// Pipelined multiply / multiply-accumulate lane with valid tracking.
// Define TOP_MUL_SAT_EN for saturating accumulation with a sticky ovf flag.
module top_mul_pipe_mac
  import top_mul_pkg::*;
#(
  parameter int DIN0_WIDTH  = 9,
  parameter int DIN1_WIDTH  = 12,
  parameter int DOUT_WIDTH  = 24,
  parameter int NUM_STAGE   = 2,
  parameter int SIGNED_MODE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  acc_en,
  input  logic                  acc_first,
  output logic                  out_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);
  localparam int CW = $bits(stage_ctl_t);
  localparam int DW = DOUT_WIDTH + CW;

  generate
    if (DOUT_WIDTH < PW) begin : g_err_width
      $error("DOUT_WIDTH must be >= DIN0_WIDTH + DIN1_WIDTH");
    end
    if (NUM_STAGE < 2) begin : g_err_stage
      $error("NUM_STAGE must be >= 2");
    end
  endgenerate

  logic [DIN0_WIDTH-1:0] a_r;
  logic [DIN1_WIDTH-1:0] b_r;
  stage_ctl_t            ctl_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_r   <= '0;
      b_r   <= '0;
      ctl_r <= '0;
    end else if (ce) begin
      a_r   <= din0;
      b_r   <= din1;
      ctl_r <= '{valid: in_valid, acc_en: acc_en, acc_first: acc_first};
    end
  end

  // Operands are extended to the full product width so one PW-bit multiply is exact.
  logic [PW-1:0]         opa, opb, prod;
  logic [DOUT_WIDTH-1:0] prod_x;

  generate
    if (SIGNED_MODE != 0) begin : g_sgn
      assign opa    = PW'($signed(a_r));
      assign opb    = PW'($signed(b_r));
      assign prod_x = DOUT_WIDTH'($signed(prod));
    end else begin : g_uns
      assign opa    = PW'(a_r);
      assign opb    = PW'(b_r);
      assign prod_x = DOUT_WIDTH'(prod);
    end
  endgenerate

  assign prod = opa * opb;

  logic [DW-1:0]         dly_q;
  stage_ctl_t            ctl_f;
  logic [DOUT_WIDTH-1:0] prod_f;

  top_mul_pipe_delay #(.W(DW), .DEPTH(NUM_STAGE - 2)) u_dly (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .d     ({ctl_r, prod_x}),
    .q     (dly_q)
  );

  assign {ctl_f, prod_f} = dly_q;

  logic                  restart;
  logic [DOUT_WIDTH-1:0] acc_next;

  assign restart = !ctl_f.acc_en || ctl_f.acc_first;

`ifdef TOP_MUL_SAT_EN
  generate
    if (DOUT_WIDTH > SAT_W) begin : g_err_sat
      $error("DOUT_WIDTH too wide for saturating accumulate");
    end
  endgenerate

  logic [SAT_W-1:0] acc_w, prod_w;
  logic [SAT_W:0]   sat_r;

  assign acc_w    = (SIGNED_MODE != 0) ? SAT_W'($signed(dout))   : SAT_W'(dout);
  assign prod_w   = (SIGNED_MODE != 0) ? SAT_W'($signed(prod_f)) : SAT_W'(prod_f);
  assign sat_r    = sat_add(acc_w, prod_w, DOUT_WIDTH, SIGNED_MODE != 0);
  assign acc_next = sat_r[DOUT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (ce && ctl_f.valid) begin
      if (restart)             ovf <= 1'b0;
      else if (sat_r[SAT_W])   ovf <= 1'b1;
    end
  end
`else
  assign acc_next = dout + prod_f;
  assign ovf      = 1'b0;
`endif

  // Accumulator feedback lives only in this register, so back-to-back beats need no interlock.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
    end else if (ce) begin
      out_valid <= ctl_f.valid;
      if (ctl_f.valid) dout <= restart ? prod_f : acc_next;
    end
  end

endmodule

// File: tb/tb_top_mul_pipe_mac.sv
// Bench for top_mul_pipe_mac: three instances (unsigned/2, signed/2, unsigned/4) on shared stimulus.
module tb_top_mul_pipe_mac;

  typedef struct {
    logic [23:0] d;
    logic        o;
    int          due;
  } sb_t;

  typedef struct {
    logic [8:0]  a;
    logic [11:0] b;
    logic        first;
    logic [23:0] exp_u;
    logic [23:0] exp_s;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, ce = 1'b1, in_valid = 1'b0, acc_en = 1'b0, acc_first = 1'b0;
  logic [8:0]  din0 = '0;
  logic [11:0] din1 = '0;

  logic        ov[3];
  logic [23:0] dv[3];
  logic        of[3];

  always #5 clk = ~clk;

  top_mul_pipe_mac u_def (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_en(acc_en), .acc_first(acc_first), .out_valid(ov[0]), .dout(dv[0]), .ovf(of[0]));

  top_mul_pipe_mac #(.SIGNED_MODE(1)) u_sgn (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_en(acc_en), .acc_first(acc_first), .out_valid(ov[1]), .dout(dv[1]), .ovf(of[1]));

  top_mul_pipe_mac #(.NUM_STAGE(4)) u_acc (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_en(acc_en), .acc_first(acc_first), .out_valid(ov[2]), .dout(dv[2]), .ovf(of[2]));

  sb_t         sbq[3][$];
  logic [23:0] acc_m[3], last_d[3], prev_d[3];
  logic        ovf_m[3], last_o[3], prev_o[3], prev_v[3];
  int          cyc, n_tests, n_fail;
  vec_t        tbl[7];

  function automatic int nst(input int d);
    return (d == 2) ? 4 : 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, req, req, cyc);
    end
  endtask

  function automatic void model_beat(input int d);
    longint sa, sb, p, cur, s;
    logic [23:0] nv;
    logic no;
    if (d == 1) begin
      sa  = longint'($signed(din0));
      sb  = longint'($signed(din1));
      cur = longint'($signed(acc_m[d]));
    end else begin
      sa  = longint'(din0);
      sb  = longint'(din1);
      cur = longint'(acc_m[d]);
    end
    p = sa * sb;
    if (!acc_en || acc_first) begin
      nv = 24'(p);
      no = 1'b0;
    end else begin
      s = cur + p;
`ifdef TOP_MUL_SAT_EN
      if (d == 1 && s > 64'sd8388607)        begin nv = 24'h7FFFFF; no = 1'b1; end
      else if (d == 1 && s < -64'sd8388608)  begin nv = 24'h800000; no = 1'b1; end
      else if (d != 1 && s > 64'sd16777215)  begin nv = 24'hFFFFFF; no = 1'b1; end
      else                                   begin nv = 24'(s);     no = ovf_m[d]; end
`else
      nv = 24'(s);
      no = 1'b0;
`endif
    end
    acc_m[d] = nv;
    ovf_m[d] = no;
    sbq[d].push_back('{d: nv, o: no, due: cyc + nst(d) - 1});
  endfunction

  task automatic monitor(input logic adv);
    sb_t e;
    for (int d = 0; d < 3; d++) begin
      if (!adv) begin
        chk($sformatf("stall_valid[%0d]", d), ov[d], prev_v[d]);
        chk($sformatf("stall_dout[%0d]", d), dv[d], prev_d[d]);
        chk($sformatf("stall_ovf[%0d]", d), of[d], prev_o[d]);
      end else if (ov[d]) begin
        if (sbq[d].size() == 0) begin
          chk($sformatf("stale_beat[%0d]", d), ov[d], 0);
        end else begin
          e = sbq[d].pop_front();
          chk($sformatf("dout[%0d]", d), dv[d], e.d);
          chk($sformatf("ovf[%0d]", d), of[d], e.o);
          chk($sformatf("latency[%0d]", d), cyc, e.due);
          last_d[d] = e.d;
          last_o[d] = e.o;
        end
      end else begin
        chk($sformatf("hold_dout[%0d]", d), dv[d], last_d[d]);
        chk($sformatf("hold_ovf[%0d]", d), of[d], last_o[d]);
        if (sbq[d].size() > 0 && sbq[d][0].due <= cyc) begin
          chk($sformatf("missing_beat[%0d]", d), ov[d], 1);
          void'(sbq[d].pop_front());
        end
      end
      prev_v[d] = ov[d];
      prev_d[d] = dv[d];
      prev_o[d] = of[d];
    end
  endtask

  // Model sees exactly the inputs the DUT captures on the coming edge.
  task automatic tick();
    logic adv;
    adv = reset || ce;
    if (reset) begin
      for (int d = 0; d < 3; d++) begin
        sbq[d].delete();
        acc_m[d] = '0; ovf_m[d] = 1'b0; last_d[d] = '0; last_o[d] = 1'b0;
      end
    end else if (ce) begin
      cyc++;
      if (in_valid) for (int d = 0; d < 3; d++) model_beat(d);
    end
    @(posedge clk);
    @(negedge clk);
    monitor(adv);
  endtask

  task automatic beat(input logic v, input logic [8:0] a, input logic [11:0] b,
                      input logic en, input logic first);
    in_valid = v; din0 = a; din1 = b; acc_en = en; acc_first = first;
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    tbl[0] = '{a: 9'd511,   b: 12'd4095,  first: 1'b0, exp_u: 24'h1FEE01, exp_s: 24'h000001};
    tbl[1] = '{a: 9'h1FF,   b: 12'd5,     first: 1'b0, exp_u: 24'h0009FB, exp_s: 24'hFFFFFB};
    tbl[2] = '{a: 9'd0,     b: 12'd4095,  first: 1'b0, exp_u: 24'h000000, exp_s: 24'h000000};
    tbl[3] = '{a: 9'h100,   b: 12'h800,   first: 1'b0, exp_u: 24'h080000, exp_s: 24'h080000};
    tbl[4] = '{a: 9'd255,   b: 12'd2047,  first: 1'b0, exp_u: 24'h07F701, exp_s: 24'h07F701};
    tbl[5] = '{a: 9'd3,     b: 12'd4094,  first: 1'b0, exp_u: 24'h002FFA, exp_s: 24'hFFFFFA};
    tbl[6] = '{a: 9'd2,     b: 12'd3,     first: 1'b1, exp_u: 24'h000006, exp_s: 24'h000006};

    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_valid[%0d]", d), ov[d], 0);
      chk($sformatf("reset_dout[%0d]", d), dv[d], 0);
      chk($sformatf("reset_ovf[%0d]", d), of[d], 0);
    end

    // Plain multiplies; acc_first without acc_en must be ignored.
    for (int i = 0; i < 7; i++) begin
      beat(1'b1, tbl[i].a, tbl[i].b, 1'b0, tbl[i].first);
      idle(1);
      chk($sformatf("vec%0d_valid", i), ov[0], 1);
      chk($sformatf("vec%0d_unsigned", i), dv[0], tbl[i].exp_u);
      chk($sformatf("vec%0d_signed", i), dv[1], tbl[i].exp_s);
    end
    idle(4);

    // Accumulate through a bubble on the 4-stage lane: results at cycles 4, 5, 7.
    beat(1'b1, 9'd3, 12'd4, 1'b1, 1'b1);
    beat(1'b1, 9'd5, 12'd6, 1'b1, 1'b0);
    beat(1'b0, 9'd0, 12'd0, 1'b1, 1'b0);
    beat(1'b1, 9'd7, 12'd8, 1'b1, 1'b0);
    chk("acc_c4_valid", ov[2], 1);
    chk("acc_c4_dout", dv[2], 12);
    idle(1);
    chk("acc_c5_dout", dv[2], 42);
    idle(1);
    chk("acc_c6_valid", ov[2], 0);
    chk("acc_c6_hold", dv[2], 42);
    idle(1);
    chk("acc_c7_valid", ov[2], 1);
    chk("acc_c7_dout", dv[2], 98);
    idle(3);
    chk("acc_final_def", dv[0], 98);

    // Stall with two beats in flight; garbage presented while ce=0 must be ignored.
    beat(1'b1, 9'd10, 12'd20, 1'b0, 1'b0);
    beat(1'b1, 9'd7,  12'd9,  1'b0, 1'b0);
    ce = 1'b0; in_valid = 1'b1; din0 = 9'd100; din1 = 12'd100;
    repeat (3) tick();
    ce = 1'b1;
    idle(6);
    chk("stall_final_acc", dv[2], 63);

    // Reset with beats in flight: nothing stale may emerge afterwards.
    beat(1'b1, 9'd1, 12'd2, 1'b0, 1'b0);
    beat(1'b1, 9'd3, 12'd4, 1'b0, 1'b0);
    beat(1'b1, 9'd5, 12'd6, 1'b0, 1'b0);
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("midreset_valid[%0d]", d), ov[d], 0);
      chk($sformatf("midreset_dout[%0d]", d), dv[d], 0);
    end
    idle(6);

    // Ten maximal accumulates: wraps by default, saturates with TOP_MUL_SAT_EN.
    beat(1'b1, 9'd511, 12'd4095, 1'b1, 1'b1);
    repeat (9) beat(1'b1, 9'd511, 12'd4095, 1'b1, 1'b0);
    idle(5);
`ifdef TOP_MUL_SAT_EN
    chk("sat_final_dout", dv[0], 24'hFFFFFF);
    chk("sat_final_ovf", of[0], 1);
`else
    chk("wrap_final_dout", dv[0], 4148234);
    chk("wrap_final_ovf", of[0], 0);
`endif
    chk("acc_signed_sum", dv[1], 10);
    beat(1'b1, 9'd511, 12'd4095, 1'b1, 1'b1);
    idle(5);
    chk("restart_dout", dv[0], 2092545);
    chk("restart_ovf", of[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
